// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
//   mdu_op_t     - 3-bit EX-stage operation encoding
//   mdu_state_t  - control FSM states
//   MDU_DIV_CYCLES / MDU_XLEN - divide iteration count and operand width
//   cond_neg     - two's-complement negate when a flag is set
package hilo_mdu_pkg;

    localparam int unsigned MDU_XLEN       = 32;
    localparam int unsigned MDU_DIV_CYCLES = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_RUN  = 2'd1,
        ST_DIV_DONE = 2'd2
    } mdu_state_t;

    // Negate v when neg is set (magnitude conversion and sign fix-up).
    function automatic logic [MDU_XLEN-1:0] cond_neg(input logic [MDU_XLEN-1:0] v,
                                                     input logic                neg);
        return neg ? (~v + MDU_XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// hilo_div_iter: radix-2 restoring divider datapath, one step per cycle.
//   clk, rst_n    - clock, async active-low reset
//   load_i        - latch dividend/divisor, clear remainder, load counter
//   step_i        - perform one restoring step and decrement the counter
//   dividend_i    - unsigned dividend magnitude
//   divisor_i     - unsigned divisor magnitude
//   quo_o, rem_o  - unsigned quotient / remainder (valid after the last step)
//   cnt_zero_c_o  - counter is at zero (current step is the last one)
module hilo_div_iter
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [MDU_XLEN-1:0] dividend_i,
    input  logic [MDU_XLEN-1:0] divisor_i,
    output logic [MDU_XLEN-1:0] quo_o,
    output logic [MDU_XLEN-1:0] rem_o,
    output logic                cnt_zero_c_o
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    logic [MDU_XLEN-1:0] rem_q, rem_d;
    logic [MDU_XLEN-1:0] quo_q, quo_d;
    logic [MDU_XLEN-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MDU_XLEN:0]   shifted;
    logic [MDU_XLEN:0]   trial;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    // quo_q doubles as the dividend shift register and quotient collector.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        shifted = {rem_q, quo_q[MDU_XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = CNT_W'(DIV_CYCLES - 1);
        end else if (step_i) begin
            if (!trial[MDU_XLEN]) begin
                rem_d = trial[MDU_XLEN-1:0];
                quo_d = {quo_q[MDU_XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[MDU_XLEN-1:0];
                quo_d = {quo_q[MDU_XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo_o        = quo_q;
    assign rem_o        = rem_q;
    assign cnt_zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: EX-stage multiply/divide unit owning architectural HI/LO.
//   clk, rst_n        - clock, async active-low reset
//   start, op, a, b   - operation issue from EX (op is mdu_op_t encoded)
//   flush             - abort in-flight divide, ignore start this cycle
//   busy              - divide in progress (hazard-unit stall)
//   res_valid         - one-cycle pulse: HI/LO updated at the previous edge
//   res_hi, res_lo    - values written at that update (ID forwarding path)
//   hi_out, lo_out    - architectural HI/LO
// Build option: define HILO_MDU_DIV_EN to include the iterative divider;
// without it DIV/DIVU behave as NOP and busy stays 0.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [MDU_XLEN-1:0] a,
    input  logic [MDU_XLEN-1:0] b,
    input  logic                flush,
    output logic                busy,
    output logic                res_valid,
    output logic [MDU_XLEN-1:0] res_hi,
    output logic [MDU_XLEN-1:0] res_lo,
    output logic [MDU_XLEN-1:0] hi_out,
    output logic [MDU_XLEN-1:0] lo_out
);

    localparam int unsigned PW = 2 * MDU_XLEN;

    mdu_op_t    op_e;
    mdu_state_t state_q, state_d;

    logic [MDU_XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [MDU_XLEN-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                issue_c;

    logic                mul_signed_c;
    logic [PW-1:0]       mul_a_c, mul_b_c, prod_c;

    assign op_e    = mdu_op_t'(op);
    assign issue_c = start && !flush;

    // Single 64x64 multiplier: sign- or zero-extend the operands, keep the low 64 bits.
    assign mul_signed_c = (op_e == OP_MULT);
    assign mul_a_c      = {{MDU_XLEN{mul_signed_c & a[MDU_XLEN-1]}}, a};
    assign mul_b_c      = {{MDU_XLEN{mul_signed_c & b[MDU_XLEN-1]}}, b};
    assign prod_c       = mul_a_c * mul_b_c;

`ifdef HILO_MDU_DIV_EN
    logic                div_load_c, div_step_c, div_last_c;
    logic                div_signed_c, a_neg_c, b_neg_c;
    logic [MDU_XLEN-1:0] quo_c, rem_c, quo_fix_c, rem_fix_c;
    logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d, dvz_q, dvz_d;

    assign div_signed_c = (op_e == OP_DIV);
    assign a_neg_c      = div_signed_c & a[MDU_XLEN-1];
    assign b_neg_c      = div_signed_c & b[MDU_XLEN-1];

    // Divide-by-zero forces an all-ones quotient; the remainder path already
    // yields the dividend (sign restored) because every trial subtract succeeds.
    assign quo_fix_c = dvz_q ? '1 : cond_neg(quo_c, q_neg_q);
    assign rem_fix_c = cond_neg(rem_c, r_neg_q);

    hilo_div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (div_load_c),
        .step_i       (div_step_c),
        .dividend_i   (cond_neg(a, a_neg_c)),
        .divisor_i    (cond_neg(b, b_neg_c)),
        .quo_o        (quo_c),
        .rem_o        (rem_c),
        .cnt_zero_c_o (div_last_c)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
`ifdef HILO_MDU_DIV_EN
                ST_IDLE:     if (start && (op_e == OP_DIV || op_e == OP_DIVU)) state_d = ST_DIV_RUN;
                ST_DIV_RUN:  if (div_last_c) state_d = ST_DIV_DONE;
                ST_DIV_DONE: state_d = ST_IDLE;
`endif
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values.
    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
`ifdef HILO_MDU_DIV_EN
        div_load_c  = 1'b0;
        div_step_c  = 1'b0;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dvz_d       = dvz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            {hi_d, lo_d} = prod_c;
                            res_valid_d  = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_d        = a;
                            res_valid_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d        = a;
                            res_valid_d = 1'b1;
                        end
`ifdef HILO_MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            div_load_c = 1'b1;
                            busy_d     = 1'b1;
                            q_neg_d    = a_neg_c ^ b_neg_c;
                            r_neg_d    = a_neg_c;
                            dvz_d      = (b == '0);
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef HILO_MDU_DIV_EN
            ST_DIV_RUN: begin
                if (!flush) begin
                    div_step_c = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_DIV_DONE: begin
                if (!flush) begin
                    hi_d        = rem_fix_c;
                    lo_d        = quo_fix_c;
                    res_valid_d = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        if (res_valid_d) begin
            res_hi_d = hi_d;
            res_lo_d = lo_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q        <= '0;
            lo_q        <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef HILO_MDU_DIV_EN
    // Operand sign bookkeeping captured at divide issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dvz_q   <= dvz_d;
        end
    end
`endif

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: self-checking bench for hilo_mdu with a behavioural HI/LO model.
// Follows the HILO_MDU_DIV_EN build option of the design.
`timescale 1ns/1ps
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, res_valid;
    logic [31:0] res_hi, res_lo, hi_out, lo_out;

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    hilo_mdu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .res_valid (res_valid),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    // Reference: {HI, LO} of a 32x32 product using plain integer arithmetic.
    function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        longint sx, sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'h0, x});
            sy = longint'({32'h0, y});
        end
        return 64'(sx * sy);
    endfunction

    // Reference: {HI=remainder, LO=quotient} with the MIPS corner cases.
    function automatic logic [63:0] div_model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        int                qs, rs;
        longint unsigned   xu, yu;
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            qs = $signed(x) / $signed(y);
            rs = $signed(x) % $signed(y);
            return {32'(rs), 32'(qs)};
        end
        xu = {32'h0, x};
        yu = {32'h0, y};
        return {32'(xu % yu), 32'(xu / yu)};
    endfunction

    // Present one op for a single cycle (call at a negedge; returns one negedge later).
    task automatic issue(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NOP;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tot++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_tot++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b exp 0", res_valid); else n_pass++;
        n_tot++; if ({res_hi, res_lo} !== 64'h0) $display("FAIL rst_res got %h exp 0", {res_hi, res_lo}); else n_pass++;
        n_tot++; if ({hi_out, lo_out} !== 64'h0) $display("FAIL rst_hilo got %h exp 0", {hi_out, lo_out}); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tot++; if ({busy, res_valid, hi_out, lo_out} !== 66'h0) $display("FAIL idle_outputs got %h exp 0", {busy, res_valid, hi_out, lo_out}); else n_pass++;
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_mult();
        mdu_op_t     vop [20];
        logic [31:0] va  [20];
        logic [31:0] vb  [20];
        logic [63:0] p;
        vop[0] = OP_MULT;  va[0] = 32'hFFFF_FFFE; vb[0] = 32'd3;
        vop[1] = OP_MULTU; va[1] = 32'hFFFF_FFFE; vb[1] = 32'd3;
        vop[2] = OP_MULT;  va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000;
        vop[3] = OP_MULTU; va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF;
        for (int i = 4; i < 20; i++) begin
            vop[i] = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
            va[i]  = $urandom;
            vb[i]  = $urandom;
        end
        for (int i = 0; i < 20; i++) begin
            p = mul_model(va[i], vb[i], vop[i] == OP_MULT);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            issue(vop[i], va[i], vb[i]);
            n_tot++; if (res_valid !== 1'b1) $display("FAIL mul_valid[%0d] got %b exp 1", i, res_valid); else n_pass++;
            n_tot++; if (busy !== 1'b0) $display("FAIL mul_busy[%0d] got %b exp 0", i, busy); else n_pass++;
            n_tot++; if ({hi_out, lo_out} !== {exp_hi, exp_lo}) $display("FAIL mul_hilo[%0d] a=%h b=%h got %h exp %h", i, va[i], vb[i], {hi_out, lo_out}, {exp_hi, exp_lo}); else n_pass++;
            n_tot++; if ({res_hi, res_lo} !== {exp_hi, exp_lo}) $display("FAIL mul_res[%0d] got %h exp %h", i, {res_hi, res_lo}, {exp_hi, exp_lo}); else n_pass++;
        end
        @(negedge clk);
        n_tot++; if (res_valid !== 1'b0) $display("FAIL mul_pulse_len got %b exp 0", res_valid); else n_pass++;
        n_tot++; if ({res_hi, res_lo} !== {exp_hi, exp_lo}) $display("FAIL mul_res_hold got %h exp %h", {res_hi, res_lo}, {exp_hi, exp_lo}); else n_pass++;
    endtask

    task automatic test_back_to_back_mthi_mtlo();
        exp_hi = 32'h1234_5678;
        issue(OP_MTHI, 32'h1234_5678, 32'hDEAD_BEEF);
        n_tot++; if (res_valid !== 1'b1) $display("FAIL mthi_valid got %b exp 1", res_valid); else n_pass++;
        n_tot++; if ({res_hi, res_lo, hi_out, lo_out} !== {exp_hi, exp_lo, exp_hi, exp_lo}) $display("FAIL mthi_regs got %h exp %h", {res_hi, res_lo, hi_out, lo_out}, {exp_hi, exp_lo, exp_hi, exp_lo}); else n_pass++;
        exp_lo = 32'h9ABC_DEF0;
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        n_tot++; if (res_valid !== 1'b1) $display("FAIL mtlo_valid got %b exp 1", res_valid); else n_pass++;
        n_tot++; if ({res_hi, res_lo, hi_out, lo_out} !== {exp_hi, exp_lo, exp_hi, exp_lo}) $display("FAIL mtlo_regs got %h exp %h", {res_hi, res_lo, hi_out, lo_out}, {exp_hi, exp_lo, exp_hi, exp_lo}); else n_pass++;
        issue(OP_RSVD, 32'h5555_5555, 32'h7);
        n_tot++; if ({res_valid, busy, hi_out, lo_out} !== {2'b00, exp_hi, exp_lo}) $display("FAIL rsvd_nop got %h exp %h", {res_valid, busy, hi_out, lo_out}, {2'b00, exp_hi, exp_lo}); else n_pass++;
    endtask

`ifdef HILO_MDU_DIV_EN
    task automatic test_div();
        mdu_op_t     vop [10];
        logic [31:0] va  [10];
        logic [31:0] vb  [10];
        logic [63:0] r;
        int          n;
        vop[0] = OP_DIV;  va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;
        vop[1] = OP_DIVU; va[1] = 32'd100;       vb[1] = 32'd0;
        vop[2] = OP_DIV;  va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF;
        vop[3] = OP_DIV;  va[3] = 32'hFFFF_FFFB; vb[3] = 32'd0;
        for (int i = 4; i < 10; i++) begin
            vop[i] = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            va[i]  = $urandom;
            vb[i]  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
        end
        for (int i = 0; i < 10; i++) begin
            r = div_model(va[i], vb[i], vop[i] == OP_DIV);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            issue(vop[i], va[i], vb[i]);
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                @(negedge clk);
            end
            n_tot++; if (n != 33) $display("FAIL div_busy_cycles[%0d] got %0d exp 33", i, n); else n_pass++;
            n_tot++; if (res_valid !== 1'b1) $display("FAIL div_valid[%0d] got %b exp 1", i, res_valid); else n_pass++;
            n_tot++; if ({hi_out, lo_out} !== {exp_hi, exp_lo}) $display("FAIL div_hilo[%0d] a=%h b=%h got %h exp %h", i, va[i], vb[i], {hi_out, lo_out}, {exp_hi, exp_lo}); else n_pass++;
            n_tot++; if ({res_hi, res_lo} !== {exp_hi, exp_lo}) $display("FAIL div_res[%0d] got %h exp %h", i, {res_hi, res_lo}, {exp_hi, exp_lo}); else n_pass++;
            @(negedge clk);
            n_tot++; if (res_valid !== 1'b0) $display("FAIL div_pulse_len[%0d] got %b exp 0", i, res_valid); else n_pass++;
        end
    endtask

    task automatic test_flush();
        int seen;
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        n_tot++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b exp 1", busy); else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tot++; if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy); else n_pass++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_tot++; if (seen != 0) $display("FAIL flush_no_valid got %0d pulses exp 0", seen); else n_pass++;
        n_tot++; if ({hi_out, lo_out} !== {exp_hi, exp_lo}) $display("FAIL flush_hilo got %h exp %h", {hi_out, lo_out}, {exp_hi, exp_lo}); else n_pass++;
        flush = 1'b1;
        issue(OP_DIVU, 32'd50, 32'd5);
        flush = 1'b0;
        n_tot++; if ({busy, res_valid} !== 2'b00) $display("FAIL flush_div_start got %b exp 00", {busy, res_valid}); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        logic [63:0] r;
        int          n;
        r = div_model(32'h0001_2345, 32'hFFFF_FF00, 1'b1);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        issue(OP_DIV, 32'h0001_2345, 32'hFFFF_FF00);
        repeat (4) @(negedge clk);
        issue(OP_MULT, 32'h7777_7777, 32'h3333_3333);
        n_tot++; if (res_valid !== 1'b0) $display("FAIL busy_mult_valid got %b exp 0", res_valid); else n_pass++;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_tot++; if (res_valid !== 1'b1) $display("FAIL busy_div_valid got %b exp 1", res_valid); else n_pass++;
        n_tot++; if ({hi_out, lo_out} !== {exp_hi, exp_lo}) $display("FAIL busy_hilo got %h exp %h", {hi_out, lo_out}, {exp_hi, exp_lo}); else n_pass++;
    endtask
`else
    task automatic test_div();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        n_tot++; if ({busy, res_valid} !== 2'b00) $display("FAIL div_off_flags got %b exp 00", {busy, res_valid}); else n_pass++;
        repeat (35) @(negedge clk);
        n_tot++; if ({busy, res_valid, hi_out, lo_out} !== {2'b00, exp_hi, exp_lo}) $display("FAIL div_off_hilo got %h exp %h", {busy, res_valid, hi_out, lo_out}, {2'b00, exp_hi, exp_lo}); else n_pass++;
        issue(OP_DIVU, 32'd100, 32'd0);
        n_tot++; if ({busy, res_valid, hi_out, lo_out} !== {2'b00, exp_hi, exp_lo}) $display("FAIL divu_off got %h exp %h", {busy, res_valid, hi_out, lo_out}, {2'b00, exp_hi, exp_lo}); else n_pass++;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        issue(OP_MTHI, 32'hCAFE_F00D, 32'h0);
        flush = 1'b0;
        n_tot++; if ({res_valid, hi_out} !== {1'b0, exp_hi}) $display("FAIL flush_mthi got %h exp %h", {res_valid, hi_out}, {1'b0, exp_hi}); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        issue(OP_MULTU, 32'd6, 32'd7);
        exp_hi = 32'd0;
        exp_lo = 32'd42;
        n_tot++; if ({busy, res_valid, hi_out, lo_out} !== {2'b01, exp_hi, exp_lo}) $display("FAIL mult_after_div_off got %h exp %h", {busy, res_valid, hi_out, lo_out}, {2'b01, exp_hi, exp_lo}); else n_pass++;
    endtask
`endif

    task automatic test_flush_beats_start();
        flush = 1'b1;
        issue(OP_MULT, 32'h0000_1000, 32'h0000_1000);
        flush = 1'b0;
        n_tot++; if ({res_valid, hi_out, lo_out} !== {1'b0, exp_hi, exp_lo}) $display("FAIL flush_mult got %h exp %h", {res_valid, hi_out, lo_out}, {1'b0, exp_hi, exp_lo}); else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
        issue(OP_DIVU, 32'hFFFF_0000, 32'd3);
        repeat (10) @(negedge clk);
`ifdef HILO_MDU_DIV_EN
        n_tot++; if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy got %b exp 1", busy); else n_pass++;
`endif
        #2 rst_n = 1'b0;
        #1;
        n_tot++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else n_pass++;
        n_tot++; if ({hi_out, lo_out} !== 64'h0) $display("FAIL rst_mid_hilo got %h exp 0", {hi_out, lo_out}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        repeat (40) @(negedge clk);
        n_tot++; if ({busy, res_valid, hi_out, lo_out} !== 66'h0) $display("FAIL rst_mid_after got %h exp 0", {busy, res_valid, hi_out, lo_out}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back_mthi_mtlo();
        test_div();
        test_flush();
        test_flush_beats_start();
        test_start_while_busy();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Execute-stage multiply/divide unit owning the architectural HI and LO registers of the MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, computes products in one cycle and quotients/remainders iteratively (radix-2 restoring). It publishes the committed HI/LO values and a one-cycle result pulse. The ID-stage HI/LO forwarding mux consumes both. Division asserts `busy` so the hazard unit stalls issue.

## Interface
- `DIV_CYCLES`, 32: iteration count of the divide core; fixed at 32 for 32-bit operands.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `start`  in  1  operation valid in EX this cycle.
- `op`  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  32  rt operand: multiplier or divisor.
- `flush`  in  1  abort any in-flight divide and ignore `start` this cycle.
- `busy`  out  1  divide in progress; the hazard unit stalls on it.
- `res_valid`  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- `res_hi`  out  32  HI value written at that update; feeds the ID mux forwarding path.
- `res_lo`  out  32  LO value written at that update.
- `hi_out`  out  32  architectural HI.
- `lo_out`  out  32  architectural LO.

## Operation
- State machine has three states: IDLE, DIV_RUN, DIV_DONE.
- Reset drives the state to IDLE and clears every output: `busy`=0, `res_valid`=0, `res_hi`=`res_lo`=`hi_out`=`lo_out`=0.
- IDLE, `start` with MULT/MULTU: 64-bit product of `a`×`b` (signed or unsigned). HI gets [63:32] and LO gets [31:0] at the next edge. State stays IDLE.
- IDLE, `start` with MTHI or MTLO: the selected register gets `a` at the next edge. The other register is unchanged. `res_hi`/`res_lo` show both resulting values.
- IDLE, `start` with DIV/DIVU: latch operands. Signed operands are converted to magnitudes and their signs are recorded. Go to DIV_RUN and load the counter with `DIV_CYCLES`-1.
- DIV_RUN: one restoring step per cycle; the counter decrements. When the counter reaches 0, go to DIV_DONE.
- DIV_DONE: apply sign fix. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign. Write HI=remainder and LO=quotient. Return to IDLE.
- Divide by zero is not trapped. The result is LO=0xFFFFFFFF and HI=dividend (signed case: HI=`a` unchanged).
- DIV 0x80000000 / 0xFFFFFFFF produces LO=0x80000000 and HI=0.
- `start` while `busy` is ignored; upstream must be stalled.
- `flush` in any state returns to IDLE at the next edge with HI/LO unchanged and no `res_valid`.
- When `flush` and `start` occur in the same cycle, `flush` wins.
- Reset during DIV_RUN aborts the divide immediately.

## Timing
- MULT/MTHI/MTLO accepted in cycle T: HI/LO updated at edge T→T+1, and `res_valid`=1 in T+1. `busy` is never asserted for these ops.
- DIV accepted in cycle T: `busy`=1 during cycles T+1 through T+33 (32 DIV_RUN cycles plus DIV_DONE). HI/LO are written at the end of T+33. `res_valid`=1 in T+34, the same cycle `busy` falls.
- `busy` is registered; the hazard unit ORs it with the EX-stage `start`&&div decode.
- `res_valid` lasts exactly one cycle. `res_hi`/`res_lo` hold their last value afterwards.

## Configuration
- With `HILO_MDU_DIV_EN` defined: full behaviour as above.
- With `HILO_MDU_DIV_EN` undefined: the divide core and the DIV_RUN/DIV_DONE states are removed. DIV/DIVU are treated as NOP: no HI/LO write, no `res_valid`, and `busy` is tied to 0.

## Structure
- The shared pipeline package holds:
  - the `mdu_op_t` 3-bit enum for the op encoding above;
  - the `MDU_DIV_CYCLES`=32 constant;
  - the state enum `mdu_state_t`.
- Sub-module `hilo_div_iter` contains the 32-step restoring divider datapath (partial remainder, quotient shift register, counter). The top level keeps the FSM, sign handling, multiplier and HI/LO registers.

## Test plan
- Reset then idle: all outputs 0. Assert `rst_n` low mid-divide → `busy` drops asynchronously and HI/LO return to 0.
- MULT a=0xFFFFFFFE (−2), b=3 in cycle T → HI=0xFFFFFFFF, LO=0xFFFFFFFA, `res_valid` in T+1, `busy` never high. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=−7, b=2 → `busy` for 33 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1), `res_valid` pulse in the cycle `busy` falls.
- DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → `res_valid` on both following cycles with correct `res_hi`/`res_lo`. DIV started and then `flush` at cycle 10 → HI/LO unchanged, no `res_valid`, `busy` 0 next cycle.
- `start` of MULT during `busy` → ignored: HI/LO after the divide completes reflect only the divide.
